// File: rtl/case_4_accum_pkg.sv
// Shared definitions for the case_4 product accumulator.
//   - Default widths, which match the case_4 multiplier wrapper.
//   - Saturation limits for the default accumulator width.
//   - The block-control state encoding.
package case_4_accum_pkg;

  localparam int PROD_WIDTH_DEF = 9;
  localparam int ACC_WIDTH_DEF  = 16;
  localparam int LEN_WIDTH_DEF  = 8;

  localparam int ACC_MAX = (1 << (ACC_WIDTH_DEF - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_WIDTH_DEF - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/case_4_prod_accum_if.sv
// Block-control and data handshake bundle for case_4_prod_accum.
//   master : the environment (start, len, product stream in; results out)
//   slave  : the accumulator block
// Signal names follow the ap_ctrl_hs / ap_vld+ap_ack port naming.
interface case_4_prod_accum_if #(
  parameter int PROD_WIDTH = 9,
  parameter int ACC_WIDTH  = 16,
  parameter int LEN_WIDTH  = 8
);

  logic                         ap_start;
  logic                         ap_done;
  logic                         ap_idle;
  logic                         ap_ready;
  logic [LEN_WIDTH-1:0]         len;
  logic signed [PROD_WIDTH-1:0] prod_din;
  logic                         prod_din_ap_vld;
  logic                         prod_din_ap_ack;
  logic signed [ACC_WIDTH-1:0]  acc_dout;
  logic                         acc_dout_ap_vld;
  logic                         sat_flag;

  modport master (
    output ap_start, len, prod_din, prod_din_ap_vld,
    input  ap_done, ap_idle, ap_ready, prod_din_ap_ack,
           acc_dout, acc_dout_ap_vld, sat_flag
  );

  modport slave (
    input  ap_start, len, prod_din, prod_din_ap_vld,
    output ap_done, ap_idle, ap_ready, prod_din_ap_ack,
           acc_dout, acc_dout_ap_vld, sat_flag
  );

endinterface

// File: rtl/case_4_sat_add.sv
// Combinational saturating adder: acc + sext(prod), clamped to the signed
// ACC_WIDTH range.
//   prod : signed PROD_WIDTH operand (PROD_WIDTH <= ACC_WIDTH)
//   acc  : signed ACC_WIDTH operand
//   sum  : clamped signed ACC_WIDTH result
//   sat  : high when clamping occurred
module case_4_sat_add
  import case_4_accum_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic signed [PROD_WIDTH-1:0] prod,
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [ACC_WIDTH-1:0]  sum,
  output logic                         sat
);

  // One guard bit is enough: the sum of an ACC_WIDTH and a narrower operand
  // always fits in ACC_WIDTH+1 bits, and overflow shows up as the two top
  // bits disagreeing.
  function automatic logic signed [ACC_WIDTH-1:0] sat_clip(
    input logic signed [ACC_WIDTH:0] v
  );
    if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) begin
      return v[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return v[ACC_WIDTH-1:0];
  endfunction

  logic signed [ACC_WIDTH:0] wide;

  always_comb begin
    wide = {{(ACC_WIDTH+1-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod}
         + {acc[ACC_WIDTH-1], acc};
    sat  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    sum  = sat_clip(wide);
  end

endmodule

// File: rtl/case_4_prod_accum.sv
// Per-run saturating accumulator placed after the case_4 multiplier.
// A start request latches a run length; that many signed products are then
// accepted over a vld/ack handshake and summed with saturation. The result is
// published for one cycle under an ap_ctrl_hs-style done/ready pulse and held
// until the next run completes.
//   ap_clk   : clock, rising edge
//   ap_rst_n : synchronous active-low reset
//   bus      : slave side of case_4_prod_accum_if (start/len, product stream,
//              done/idle/ready, acc_dout + acc_dout_ap_vld, sat_flag)
module case_4_prod_accum
  import case_4_accum_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input logic               ap_clk,
  input logic               ap_rst_n,
  case_4_prod_accum_if.slave bus
);

  state_e                      state_q, state_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] acc_dout_q, acc_dout_d;
  logic                        sat_q, sat_d;

  logic signed [ACC_WIDTH-1:0] add_sum;
  logic                        add_sat;

  case_4_sat_add #(
    .PROD_WIDTH (PROD_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat_add (
    .prod (bus.prod_din),
    .acc  (acc_q),
    .sum  (add_sum),
    .sat  (add_sat)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    acc_dout_d = acc_dout_q;
    sat_d      = sat_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
          if (bus.len != '0) begin
            len_d   = bus.len;
            state_d = ACCUM;
          end else begin
            // Empty run: publish a zero result straight away.
            acc_dout_d = '0;
            state_d    = DONE;
          end
        end
      end

      ACCUM: begin
        // ack is constant-high here, so a valid product is always taken.
        if (bus.prod_din_ap_vld) begin
          acc_d = add_sum;
          cnt_d = cnt_q + 1'b1;
          if (add_sat) sat_d = 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            acc_dout_d = add_sum;
            state_d    = DONE;
          end
        end
      end

      DONE: begin
        // Always return to IDLE so a held start is seen only after one idle
        // cycle.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_dout_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      acc_dout_q <= acc_dout_d;
      sat_q      <= sat_d;
    end
  end

  // Control outputs decode straight from the state register.
  assign bus.ap_idle         = (state_q == IDLE);
  assign bus.ap_done         = (state_q == DONE);
  assign bus.ap_ready        = (state_q == DONE);
  assign bus.acc_dout_ap_vld = (state_q == DONE);
  assign bus.prod_din_ap_ack = (state_q == ACCUM);
  assign bus.acc_dout        = acc_dout_q;
  assign bus.sat_flag        = sat_q;

endmodule

// File: tb/tb_case_4_prod_accum.sv
module tb_case_4_prod_accum;
  import case_4_accum_pkg::*;

  localparam int PW = 9;
  localparam int AW = 16;
  localparam int LW = 8;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  always #5 ap_clk = ~ap_clk;

  case_4_prod_accum_if #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  case_4_prod_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  int prods[$];
  int gaps[$];
  int prev_acc = 0;

  typedef struct {
    int len;
    int pv;
    int gap;
    int exp_acc;
    bit exp_sat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference: running sum clamped to the signed 16-bit range after each
  // sample, sticky saturation indicator.
  task automatic ref_run(output int sum, output bit sat);
    sum = 0;
    sat = 1'b0;
    foreach (prods[i]) begin
      sum = sum + prods[i];
      if (sum > ACC_MAX) begin sum = ACC_MAX; sat = 1'b1; end
      if (sum < ACC_MIN) begin sum = ACC_MIN; sat = 1'b1; end
    end
  endtask

  // Runs one transaction with the products in prods[] and the stall cycles
  // before each sample in gaps[]. Entered and left at #1 after an edge.
  task automatic do_run(input string nm);
    int  ln = prods.size();
    int  stall = 0;
    int  exp_sum;
    bit  exp_sat;
    int  idx = 0;
    int  gap;
    int  cyc;
    int  acks = 0;
    bit  got = 1'b0;
    int  done_cyc = -1;
    foreach (gaps[i]) stall += gaps[i];
    ref_run(exp_sum, exp_sat);

    bus.len             = LW'(ln);
    bus.ap_start        = 1'b1;
    bus.prod_din_ap_vld = 1'b1;       // must be ignored while idle
    bus.prod_din        = PW'(255);
    step();
    bus.ap_start        = 1'b0;
    bus.prod_din_ap_vld = 1'b0;
    cyc = 1;
    chk({nm, "_sat_clr"}, bus.sat_flag, 0);
    chk({nm, "_acc_hold"}, bus.acc_dout, prev_acc);
    chk({nm, "_busy"}, bus.ap_idle, 0);

    gap = gaps[0];
    while (cyc <= ln + stall + 5) begin
      if (bus.ap_done) begin
        got = 1'b1;
        done_cyc = cyc;
        chk({nm, "_acc"}, bus.acc_dout, exp_sum);
        chk({nm, "_sat"}, bus.sat_flag, exp_sat);
        chk({nm, "_ready"}, bus.ap_ready, 1);
        chk({nm, "_dvld"}, bus.acc_dout_ap_vld, 1);
        chk({nm, "_ack_done"}, bus.prod_din_ap_ack, 0);
        break;
      end
      if (bus.prod_din_ap_ack) begin
        acks++;
        if (gap > 0) begin
          bus.prod_din_ap_vld = 1'b0;
          bus.prod_din        = PW'($urandom);
          gap--;
        end else if (idx < ln) begin
          bus.prod_din_ap_vld = 1'b1;
          bus.prod_din        = PW'(prods[idx]);
          idx++;
          gap = (idx < ln) ? gaps[idx] : 0;
        end else begin
          bus.prod_din_ap_vld = 1'b0;
        end
      end else begin
        bus.prod_din_ap_vld = 1'b1;
        bus.prod_din        = PW'($urandom);
      end
      step();
      cyc++;
    end
    bus.prod_din_ap_vld = 1'b0;

    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_latency"}, done_cyc, ln + 1 + stall);
    chk({nm, "_ack_cycles"}, acks, ln + stall);
    step();
    chk({nm, "_pulse_end"}, bus.ap_done, 0);
    chk({nm, "_idle_after"}, bus.ap_idle, 1);
    chk({nm, "_acc_kept"}, bus.acc_dout, exp_sum);
    prev_acc = exp_sum;
  endtask

  initial begin
    int dcnt;
    bus.ap_start        = 1'b0;
    bus.len             = '0;
    bus.prod_din        = '0;
    bus.prod_din_ap_vld = 1'b0;

    tbl[0] = '{len: 200, pv:  255, gap: 0, exp_acc:  32767, exp_sat: 1'b1};
    tbl[1] = '{len:   1, pv: -256, gap: 0, exp_acc:   -256, exp_sat: 1'b0};
    tbl[2] = '{len: 128, pv:  255, gap: 0, exp_acc:  32640, exp_sat: 1'b0};
    tbl[3] = '{len: 129, pv:  255, gap: 0, exp_acc:  32767, exp_sat: 1'b1};
    tbl[4] = '{len: 128, pv: -256, gap: 0, exp_acc: -32768, exp_sat: 1'b0};
    tbl[5] = '{len:   3, pv:    7, gap: 1, exp_acc:     21, exp_sat: 1'b0};
    tbl[6] = '{len: 255, pv:   -1, gap: 0, exp_acc:   -255, exp_sat: 1'b0};
    tbl[7] = '{len: 129, pv: -256, gap: 0, exp_acc: -32768, exp_sat: 1'b1};

    // Reset held for three cycles.
    repeat (3) step();
    chk("rst_idle", bus.ap_idle, 1);
    chk("rst_done", bus.ap_done, 0);
    chk("rst_ack", bus.prod_din_ap_ack, 0);
    ap_rst_n = 1'b1;
    step();
    chk("rel_idle", bus.ap_idle, 1);
    chk("rel_done", bus.ap_done, 0);
    chk("rel_ready", bus.ap_ready, 0);
    chk("rel_dvld", bus.acc_dout_ap_vld, 0);
    chk("rel_ack", bus.prod_din_ap_ack, 0);
    chk("rel_acc", bus.acc_dout, 0);
    chk("rel_sat", bus.sat_flag, 0);

    // Basic run.
    prods = '{10, -3, 255, -256};
    gaps  = '{0, 0, 0, 0};
    do_run("basic");
    chk("basic_const", bus.acc_dout, 6);

    // Stalled run: one idle-vld cycle between samples.
    prods = '{1, 2, 3};
    gaps  = '{0, 1, 1};
    do_run("stall");
    chk("stall_const", bus.acc_dout, 6);

    // Table of constant-product runs with hand-computed results.
    for (int t = 0; t < 8; t++) begin
      prods.delete();
      gaps.delete();
      for (int i = 0; i < tbl[t].len; i++) begin
        prods.push_back(tbl[t].pv);
        gaps.push_back(tbl[t].gap);
      end
      do_run($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_acc_exp", t), bus.acc_dout, tbl[t].exp_acc);
      chk($sformatf("tbl%0d_sat_exp", t), bus.sat_flag, tbl[t].exp_sat);
    end

    // len=0 with start held: done at T+1, idle at T+2, done again at T+3.
    bus.len      = '0;
    bus.ap_start = 1'b1;
    step();
    chk("len0_done1", bus.ap_done, 1);
    chk("len0_acc1", bus.acc_dout, 0);
    chk("len0_sat1", bus.sat_flag, 0);
    chk("len0_ack1", bus.prod_din_ap_ack, 0);
    step();
    chk("len0_gap_done", bus.ap_done, 0);
    chk("len0_gap_idle", bus.ap_idle, 1);
    step();
    chk("len0_done2", bus.ap_done, 1);
    chk("len0_ack2", bus.prod_din_ap_ack, 0);
    bus.ap_start = 1'b0;
    step();
    chk("len0_idle_end", bus.ap_idle, 1);
    prev_acc = 0;

    // Reset mid-run: five samples into a ten-sample run.
    bus.len             = LW'(10);
    bus.ap_start        = 1'b1;
    step();
    bus.ap_start        = 1'b0;
    bus.prod_din_ap_vld = 1'b1;
    bus.prod_din        = PW'(100);
    dcnt = 0;
    repeat (5) begin
      step();
      if (bus.ap_done) dcnt++;
    end
    ap_rst_n = 1'b0;
    step();
    chk("mid_rst_idle", bus.ap_idle, 1);
    chk("mid_rst_ack", bus.prod_din_ap_ack, 0);
    chk("mid_rst_done", bus.ap_done, 0);
    chk("mid_rst_acc", bus.acc_dout, 0);
    chk("mid_rst_sat", bus.sat_flag, 0);
    ap_rst_n = 1'b1;
    repeat (12) begin
      step();
      if (bus.ap_done) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    chk("mid_rst_idle2", bus.ap_idle, 1);
    bus.prod_din_ap_vld = 1'b0;
    prev_acc = 0;
    prods = '{10, -3, 255, -256};
    gaps  = '{0, 0, 0, 0};
    do_run("after_rst");

    // Randomized runs against the reference model.
    for (int r = 0; r < 30; r++) begin
      int ln   = $urandom_range(1, (r % 5 == 0) ? 200 : 40);
      int mode = $urandom_range(0, 2);
      prods.delete();
      gaps.delete();
      for (int i = 0; i < ln; i++) begin
        if (mode == 0)      prods.push_back(200 + $urandom_range(0, 55));
        else if (mode == 1) prods.push_back(-256 + $urandom_range(0, 55));
        else                prods.push_back($urandom_range(0, 511) - 256);
        gaps.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      do_run($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
